// File: rtl/ram_sync_if.sv
// Request/response bundle between the load/store unit and ram_sync; parity pins exist only with RAM_SYNC_PARITY_EN.
// Latency: none (wires only).
// Backpressure: req_ready gates requests; responses cannot be stalled.
interface ram_sync_if #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8
) ();
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [ADDR_BITS-1:0] req_addr;
    logic [DATA_BITS-1:0] req_wdata;
    logic                 rsp_valid;
    logic [DATA_BITS-1:0] rsp_rdata;
    logic                 clearing;
`ifdef RAM_SYNC_PARITY_EN
    logic                 inj_parity_err;
    logic                 rsp_parity_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, inj_parity_err,
        input  req_ready, rsp_valid, rsp_rdata, clearing, rsp_parity_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, inj_parity_err,
        output req_ready, rsp_valid, rsp_rdata, clearing, rsp_parity_err
    );
`else
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, clearing
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, clearing
    );
`endif
endinterface

// File: rtl/ram_sync.sv
// Synchronous single-port RAM with post-reset clear; optional even parity via RAM_SYNC_PARITY_EN.
// Latency: READ_LATENCY cycles from accepted read to rsp_valid; writes complete at the accepting edge.
// Backpressure: req_ready low during the clear sequence only; responses are never stalled.
module ram_sync #(
    parameter int ADDR_BITS    = 4,
    parameter int DATA_BITS    = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic      clk,
    input  logic      reset,
    ram_sync_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_BITS;
`ifdef RAM_SYNC_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int WORD_BITS = DATA_BITS + PAR_BITS;
    localparam logic [ADDR_BITS:0] LAST_CNT = (ADDR_BITS + 1)'(DEPTH - 1);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("ram_sync: READ_LATENCY must be in 1..4");
        end
    endgenerate

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                 state, state_nxt;
    logic [ADDR_BITS:0]     clear_cnt, clear_cnt_nxt;
    logic                   accept;
    logic                   rd_acc;
    logic                   wr_en;
    logic [ADDR_BITS-1:0]   wr_addr;
    logic [WORD_BITS-1:0]   wr_word;
    logic [WORD_BITS-1:0]   fresh_word;
    logic [WORD_BITS-1:0]   rd_word;
    logic [WORD_BITS-1:0]   rd_stage;
    logic [WORD_BITS-1:0]   mem [DEPTH];
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [WORD_BITS-1:0]   pipe_dat [READ_LATENCY];

    assign accept = bus.req_valid && (state == ST_RUN);
    assign rd_acc = accept && !bus.req_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_CLEAR;
            clear_cnt <= '0;
        end else begin
            state     <= state_nxt;
            clear_cnt <= clear_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        clear_cnt_nxt = clear_cnt;
        bus.req_ready = 1'b0;
        bus.clearing  = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = bus.req_addr;
        wr_word       = fresh_word;
        case (state)
            ST_CLEAR: begin
                bus.clearing  = 1'b1;
                wr_en         = 1'b1;
                wr_addr       = clear_cnt[ADDR_BITS-1:0];
                wr_word       = '0;
                clear_cnt_nxt = clear_cnt + 1'b1;
                if (clear_cnt == LAST_CNT) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                bus.req_ready = 1'b1;
                wr_en         = accept && bus.req_write;
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    // Stored word is {parity, data} when parity is enabled; the read stage
    // carries {mismatch, data} so the check happens once, at array read.
`ifdef RAM_SYNC_PARITY_EN
    assign fresh_word = {(^bus.req_wdata) ^ bus.inj_parity_err, bus.req_wdata};
    assign rd_stage   = {rd_word[DATA_BITS] ^ (^rd_word[DATA_BITS-1:0]), rd_word[DATA_BITS-1:0]};
`else
    assign fresh_word = bus.req_wdata;
    assign rd_stage   = rd_word;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    assign rd_word = mem[bus.req_addr];

    // Data registers load only behind a valid bit, so the output stage holds
    // its last response while rsp_valid is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_acc;
            if (rd_acc) begin
                pipe_dat[0] <= rd_stage;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_dat[i] <= pipe_dat[i-1];
                end
            end
        end
    end

    assign bus.rsp_valid = pipe_vld[READ_LATENCY-1];
    assign bus.rsp_rdata = pipe_dat[READ_LATENCY-1][DATA_BITS-1:0];
`ifdef RAM_SYNC_PARITY_EN
    assign bus.rsp_parity_err = pipe_vld[READ_LATENCY-1] && pipe_dat[READ_LATENCY-1][DATA_BITS];
`endif

endmodule

// File: tb/tb_ram_sync.sv
// Bench for ram_sync: three instances (READ_LATENCY 1, 3, 4) share one request stream;
// responses are checked against hand-computed expectations with per-instance due cycles.
module tb_ram_sync;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [3:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       inj = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_sync_if #(.ADDR_BITS(4), .DATA_BITS(8)) if_a ();
    ram_sync_if #(.ADDR_BITS(4), .DATA_BITS(8)) if_b ();
    ram_sync_if #(.ADDR_BITS(4), .DATA_BITS(8)) if_c ();

    ram_sync #(.ADDR_BITS(4), .DATA_BITS(8), .READ_LATENCY(1)) u_dut_l1 (.clk(clk), .reset(reset), .bus(if_a.slave));
    ram_sync #(.ADDR_BITS(4), .DATA_BITS(8), .READ_LATENCY(3)) u_dut_l3 (.clk(clk), .reset(reset), .bus(if_b.slave));
    ram_sync #(.ADDR_BITS(4), .DATA_BITS(8), .READ_LATENCY(4)) u_dut_l4 (.clk(clk), .reset(reset), .bus(if_c.slave));

    assign if_a.req_valid = req_valid; assign if_a.req_write = req_write;
    assign if_a.req_addr  = req_addr;  assign if_a.req_wdata = req_wdata;
    assign if_b.req_valid = req_valid; assign if_b.req_write = req_write;
    assign if_b.req_addr  = req_addr;  assign if_b.req_wdata = req_wdata;
    assign if_c.req_valid = req_valid; assign if_c.req_write = req_write;
    assign if_c.req_addr  = req_addr;  assign if_c.req_wdata = req_wdata;

    logic       rv  [3];
    logic [7:0] rd  [3];
    logic       pe  [3];
    logic       rdy [3];
    logic       clr [3];

    assign rv[0] = if_a.rsp_valid; assign rd[0] = if_a.rsp_rdata;
    assign rv[1] = if_b.rsp_valid; assign rd[1] = if_b.rsp_rdata;
    assign rv[2] = if_c.rsp_valid; assign rd[2] = if_c.rsp_rdata;
    assign rdy[0] = if_a.req_ready; assign clr[0] = if_a.clearing;
    assign rdy[1] = if_b.req_ready; assign clr[1] = if_b.clearing;
    assign rdy[2] = if_c.req_ready; assign clr[2] = if_c.clearing;

`ifdef RAM_SYNC_PARITY_EN
    assign if_a.inj_parity_err = inj;
    assign if_b.inj_parity_err = inj;
    assign if_c.inj_parity_err = inj;
    assign pe[0] = if_a.rsp_parity_err;
    assign pe[1] = if_b.rsp_parity_err;
    assign pe[2] = if_c.rsp_parity_err;
`else
    assign pe[0] = 1'b0;
    assign pe[1] = 1'b0;
    assign pe[2] = 1'b0;
`endif

    typedef struct packed {
        int       due;
        logic [7:0] dat;
        logic     perr;
    } exp_t;

    exp_t       exp_q [3][$];
    logic [7:0] last_dat [3];

    typedef struct {
        bit       wr;
        bit [3:0] addr;
        bit [7:0] wdata;
        bit [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic int lat(int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic chk(string nm, int d, logic [15:0] act, logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s dut_l%0d cyc=%0d: got %h want %h", nm, lat(d), cyc, act, want);
        end
    endtask

    // {rsp_valid, rsp_parity_err, rsp_rdata}; with no response due the data must hold.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                if (exp_q[d].size() > 0 && exp_q[d][0].due == cyc) begin
                    exp_t e;
                    e = exp_q[d].pop_front();
                    chk("rsp", d, {6'd0, rv[d], pe[d], rd[d]}, {6'd0, 1'b1, e.perr, e.dat});
                    last_dat[d] = e.dat;
                end else begin
                    chk("idle", d, {6'd0, rv[d], pe[d], rd[d]}, {6'd0, 1'b0, 1'b0, last_dat[d]});
                end
            end
        end
    end

    task automatic push_exp(int d, int due, logic [7:0] dat, logic perr);
        exp_t e;
        e.due = due;
        e.dat = dat;
        e.perr = perr;
        exp_q[d].push_back(e);
    endtask

    // Called just after a rising edge; one request, accepted at the next edge.
    task automatic issue(bit wr, bit [3:0] a, bit [7:0] wd, bit [7:0] ex, bit inj_i, bit epe);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        inj       = inj_i;
        if (!wr) begin
            for (int d = 0; d < 3; d++) push_exp(d, cyc + lat(d), ex, epe);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        inj       = 1'b0;
    endtask

    task automatic reset_state_check();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_ready", d, {15'd0, rdy[d]}, 16'd0);
            chk("rst_clearing", d, {15'd0, clr[d]}, 16'd1);
        end
        @(posedge clk); #1;
    endtask

    // Releases reset and holds a read of addr 3 through the whole clear sequence.
    task automatic clear_seq();
        int c0;
        c0 = cyc;
        reset     = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd3;
        for (int d = 0; d < 3; d++) push_exp(d, c0 + 16 + lat(d), 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk("clr_state", d, {14'd0, clr[d], rdy[d]}, {14'd0, 1'b1, 1'b0});
            end
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("run_state", d, {14'd0, clr[d], rdy[d]}, {14'd0, 1'b0, 1'b1});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk("drain", d, 16'(exp_q[d].size()), 16'd0);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) last_dat[d] = 8'h00;

        for (int a = 0; a < 16; a++) vecs.push_back('{1'b0, 4'(a), 8'h00, 8'h00});
        vecs.push_back('{1'b1, 4'd0,  8'h00, 8'h00});
        vecs.push_back('{1'b1, 4'd1,  8'h01, 8'h00});
        vecs.push_back('{1'b1, 4'd2,  8'h02, 8'h00});
        vecs.push_back('{1'b0, 4'd2,  8'h00, 8'h02});
        vecs.push_back('{1'b0, 4'd1,  8'h00, 8'h01});
        vecs.push_back('{1'b0, 4'd0,  8'h00, 8'h00});
        vecs.push_back('{1'b1, 4'd5,  8'hA5, 8'h00});
        vecs.push_back('{1'b0, 4'd5,  8'h00, 8'hA5});
        vecs.push_back('{1'b1, 4'd15, 8'hFF, 8'h00});
        vecs.push_back('{1'b0, 4'd15, 8'h00, 8'hFF});
        vecs.push_back('{1'b0, 4'd14, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 4'd7,  8'h5A, 8'h00});
        vecs.push_back('{1'b0, 4'd7,  8'h00, 8'h5A});
        vecs.push_back('{1'b1, 4'd5,  8'h3C, 8'h00});
        vecs.push_back('{1'b0, 4'd5,  8'h00, 8'h3C});

        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        reset_state_check();
        clear_seq();

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 1'b0, 1'b0);
        end
        drain();

`ifdef RAM_SYNC_PARITY_EN
        issue(1'b1, 4'd4, 8'h3C, 8'h00, 1'b1, 1'b0);
        issue(1'b0, 4'd4, 8'h00, 8'h3C, 1'b0, 1'b1);
        issue(1'b1, 4'd4, 8'h3C, 8'h00, 1'b0, 1'b0);
        issue(1'b0, 4'd4, 8'h00, 8'h3C, 1'b0, 1'b0);
        drain();
`endif

        // Read of addr 7, then reset one cycle later: only the latency-1 instance answers.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd7;
        push_exp(0, cyc + 1, 8'h5A, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("l1_before_reset", 0, 16'(exp_q[0].size()), 16'd0);
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            exp_q[d].delete();
            last_dat[d] = 8'h00;
        end
        reset_state_check();
        clear_seq();

        issue(1'b0, 4'd7, 8'h00, 8'h00, 1'b0, 1'b0);
        issue(1'b0, 4'd5, 8'h00, 8'h00, 1'b0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_sync.md
Name: ram_sync

Overview:
Synchronous single-port RAM for the processor's data and program memory. It replaces the unclocked tristate-bus RAM with the following:
- separate read and write data buses;
- a valid/ready request interface;
- a parametrised read pipeline;
- a hardware clear sequence after reset.

It sits between the core's load/store unit and the memory array.

Parameters:
ADDR_BITS, 4, address width; depth = 2**ADDR_BITS words
DATA_BITS, 8, word width in bits
READ_LATENCY, 1, cycles from accepted read to rsp_valid; legal range 1..4

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present this cycle
req_ready  output  1  block accepts a request this cycle
req_write  input  1  1 = write, 0 = read; sampled on accept
req_addr  input  ADDR_BITS  word address; sampled on accept
req_wdata  input  DATA_BITS  write data; sampled on accept when req_write=1
rsp_valid  output  1  one-cycle pulse, read data valid
rsp_rdata  output  DATA_BITS  read data, meaningful only when rsp_valid=1
clearing  output  1  high while the post-reset clear sequence runs

Behaviour:
- Reset (async assert, sync release):
  - state=CLEAR, clear counter=0;
  - req_ready=0, rsp_valid=0, rsp_rdata=0, clearing=1;
  - all read-pipeline valid bits=0.
- Reset flushes in-flight reads; no rsp_valid is produced for them. Array contents are not reset directly; CLEAR overwrites them.
- FSM states:
  - CLEAR: each cycle writes 0 to array[clear_cnt], then clear_cnt++. When clear_cnt = 2**ADDR_BITS-1 is written, go to RUN on the next edge. Total duration is 2**ADDR_BITS cycles. req_ready=0 and clearing=1 throughout.
  - RUN: req_ready=1 and clearing=0 every cycle. The state never leaves RUN except via reset.
- Accept: a request is accepted in any cycle with req_valid & req_ready.
  - req_valid while req_ready=0 is ignored, not queued.
  - The requester must hold the request until it is accepted.
- Write: array[req_addr] <= req_wdata at the accepting edge. No response is generated.
- Read:
  - Data is taken from the array in the accepting cycle, then delayed through READ_LATENCY-1 further register stages.
  - rsp_valid is high exactly READ_LATENCY cycles after the accepting edge, for exactly one cycle.
- Throughput: fully pipelined, one request per cycle in RUN. Back-to-back reads produce back-to-back rsp_valid pulses in order.
- No response backpressure: the consumer must always sink rsp_valid.
- Ordering:
  - A read accepted the cycle after a write to the same address returns the new data.
  - A read and write cannot coincide because the block is single-port.
- rsp_rdata holds its last value when rsp_valid=0.
- Address wrap: none. Addresses are exactly ADDR_BITS wide, and the clear counter is ADDR_BITS+1 bits to detect the end.
- READ_LATENCY outside 1..4: elaboration error via $error in a generate check.

Optional Feature:
Macro RAM_SYNC_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit, computed on write. CLEAR writes data 0 with parity 0.
  - Extra input inj_parity_err (1 bit): when high on an accepted write, the stored parity bit is inverted.
  - Extra output rsp_parity_err (1 bit, reset 0): asserted alongside rsp_valid when the stored parity mismatches the read data; otherwise 0.
  - The error is report-only; data is returned unchanged.
- Undefined: no parity storage and neither extra port exists.

Test Plan:
- Reset then idle:
  - clearing=1 and req_ready=0 for exactly 16 cycles (ADDR_BITS=4), then req_ready=1.
  - Reads of addr 0..15 all return 0x00.
- Write addr 0=0x00, 1=0x01, 2=0x02; then read 2,1,0 back-to-back:
  - rsp_valid on 3 consecutive cycles, starting READ_LATENCY cycles after the first read;
  - rsp_rdata = 0x02, 0x01, 0x00.
- Write addr 5=0xA5; read addr 5 on the very next cycle -> rsp_rdata=0xA5. Repeat with READ_LATENCY=1 and READ_LATENCY=4.
- Assert req_valid (read addr 3) during CLEAR -> not accepted, no rsp_valid. The held request is accepted on the first RUN cycle.
- Issue a read with READ_LATENCY=3, then assert reset 1 cycle later:
  - rsp_valid never pulses for that read;
  - the clear sequence restarts;
  - the previously written 0x5A at addr 7 reads 0x00 afterwards.
- RAM_SYNC_PARITY_EN:
  - Write addr 4=0x3C with inj_parity_err=1, then read addr 4 -> rsp_rdata=0x3C, rsp_parity_err=1.
  - Rewrite addr 4 with inj_parity_err=0 and read -> rsp_parity_err=0.
